sms_card_dfd: RTL and testbench
===============================

// Module: sms_card_dfd
// PURPOSE
//   Clocked model of the IBM 1620 SMS "DFD" card: a set/reset latch with an
//   AND-gated clear path. Active-low set (b) forces output a=1. Active-low
//   reset (h) forces a=0. Both gate inputs e and f high also force a=0.
//   Used as a storage bit inside the 1620 SMS card-level logic model.
//   Provides true (a) and complement (g) outputs.
// PARAMETERS
//   RESET_A   1'b0   value loaded into a on rst_n; g loads ~RESET_A
// PORTS
//   clk    in   1  system clock; all state changes on rising edge
//   rst_n  in   1  reset; synchronous, active-low
//   e      in   1  AND-gate input 1 of clear path (active-high)
//   f      in   1  AND-gate input 2 of clear path (active-high)
//   h      in   1  direct reset, active-low: low -> a=0
//   b      in   1  direct set, active-low: low -> a=1
//   a      out  1  latch true output (registered)
//   g      out  1  latch complement output, always ~a
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst_n is synchronous, active-low.
//   - Single state bit q; a = q; g = ~q. Internal net n0 = ~q. n0 is kept
//     named and visible for hierarchical probing; g equals n0.
//   - rst_n=0 at a rising edge: q <= RESET_A. This overrides all inputs.
//   - Otherwise, at each rising edge, evaluate in priority order:
//       1. h==0          -> q <= 0   (direct reset; dominant)
//       2. b==0          -> q <= 1   (direct set)
//       3. e==1 && f==1  -> q <= 0   (gated clear)
//       4. else          -> q <= q   (hold)
//   - Latency: one clock from input change to a/g change. Outputs are glitch-free.
//   - e or f alone has no effect. A single high gate input must not disturb q.
//   - Simultaneous events:
//       h=0 with b=0 -> a=0.
//       b=0 with e=f=1 -> a=1.
//       Both cases assert a=0/1 consistently; there is no undefined state.
//   - Levels are honoured, not edges:
//       held b=0 keeps a=1;
//       held h=0 keeps a=0;
//       held e=f=1 keeps a=0.
//     On release, q holds its last value.
//   - Inputs are used directly at the clock edge. No synchronizers are added;
//     inputs are assumed synchronous to clk.
//   - X/Z on inputs: no special handling required. The bench drives known levels only.
//   - After reset and before any stimulus: a=RESET_A, g=~RESET_A.
// TESTING
//   1. Reset: rst_n=0 for 2 edges, e=f=0, b=h=1 -> a=0, g=1, n0=1.
//   2. Set: pulse b=0 for 1 cycle -> a=1, g=0 next edge. Release b -> a stays 1.
//   3. Reset: pulse h=0 for 1 cycle -> a=0, g=1. Pulse b=0 again -> a=1.
//   4. Gated clear: from a=1, set e=1 -> a stays 1. Then set f=1 -> a=0 next edge.
//      Drop e -> a stays 0.
//   5. Priority: h=0 and b=0 together -> a=0.
//      b=0 with e=f=1 -> a=1.
//      rst_n=0 with b=0 -> a=RESET_A.
//   6. Invariant: check g == ~a and n0 == g every cycle. Check a changes
//      only at rising clk edges.

Source files
------------

// File: rtl/sms_card_dfd.sv
// rtl/sms_card_dfd.sv - IBM 1620 SMS "DFD" card: set/reset storage bit with AND-gated clear
// Single registered bit; h (reset) dominates b (set), which dominates the e&f clear path.
module sms_card_dfd #(
  parameter logic RESET_A = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic e,
  input  logic f,
  input  logic h,
  input  logic b,
  output logic a,
  output logic g
);

  logic q;
  logic q_next;
  logic n0;

  always_comb begin
    q_next = q;
    if (!h) begin
      q_next = 1'b0;
    end else if (!b) begin
      q_next = 1'b1;
    end else if (e && f) begin
      q_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_A;
    end else begin
      q <= q_next;
    end
  end

  // Complement is derived from the register, so a and g never disagree.
  assign n0 = ~q;
  assign a  = q;
  assign g  = n0;

endmodule

// File: tb/tb_sms_card_dfd.sv
// tb/tb_sms_card_dfd.sv - directed and random scoreboard bench for sms_card_dfd
module tb_sms_card_dfd;

  localparam logic RESET_A = 1'b0;

  logic clk;
  logic rst_n;
  logic e;
  logic f;
  logic h;
  logic b;
  logic a;
  logic g;

  int checks;
  int fails;

  logic   exp_q[$];
  string  tag_q[$];
  logic   mq;
  logic   mq_valid;

  sms_card_dfd #(.RESET_A(RESET_A)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .e    (e),
    .f    (f),
    .h    (h),
    .b    (b),
    .a    (a),
    .g    (g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic got, input logic expv);
    checks++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, expv);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic rn, input logic bb, input logic hh,
                      input logic ee, input logic ff, input string tag);
    logic expv;
    string t;
    rst_n = rn; b = bb; h = hh; e = ee; f = ff;
    if (!rn)           expv = RESET_A;
    else if (!hh)      expv = 1'b0;
    else if (!bb)      expv = 1'b1;
    else if (ee && ff) expv = 1'b0;
    else               expv = mq;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    #1;
    if (mq_valid) chk({tag, "_no_early_change"}, a, mq);
    @(posedge clk);
    @(negedge clk);
    expv = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_a"}, a, expv);
    chk({t, "_g"}, g, ~expv);
    chk({t, "_n0"}, dut.n0, ~expv);
    mq = expv;
    mq_valid = 1'b1;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    mq = 1'b0;
    mq_valid = 1'b0;
    rst_n = 1'b0; b = 1'b1; h = 1'b1; e = 1'b0; f = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset2");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "idle_after_reset");

    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "set_pulse");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "set_release");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "h_pulse");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "h_release");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "set_again");

    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "e_only");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "ef_clear");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "f_only_after_clear");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "set_for_f_only");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "f_only");

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "h_and_b");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "b_and_ef");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "b_and_ef_held");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "ef_held1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "ef_held2");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b_held1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b_held2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "h_held1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "h_held2");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "set_before_rst");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_with_b");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "hold_after_rst");

    for (int i = 0; i < 60; i++) begin
      logic [4:0] r;
      r = 5'($urandom);
      step((r[4] | r[3]), r[0], (r[1] | r[2]), r[2], r[3], $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
